// File: rtl/cpu_tx_pkg.sv
// Shared types and constants for the CPU TX serializer.
//   tx_state_t : serializer FSM states
//   tx_entry_t : FIFO entry {nbytes-1, data}
//   len_ok()   : legal byte count check (1..BYTES_PER_WORD)
package cpu_tx_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned CNT_W          = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    typedef struct packed {
        logic [1:0]        nbm1;
        logic [WORD_W-1:0] data;
    } tx_entry_t;

    function automatic logic len_ok(input logic [CNT_W-1:0] nbytes);
        return (nbytes != '0) && (nbytes <= CNT_W'(BYTES_PER_WORD));
    endfunction

endpackage

// File: rtl/cpu_tx_fifo.sv
// Synchronous FIFO of tx_entry_t with wrap-around pointers.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_push, i_wdata  enqueue (caller guarantees room or same-cycle pop)
//   i_pop, o_rdata   dequeue; o_rdata is the current head
//   i_flush          drop all entries; wins over push/pop
//   o_level, o_full, o_empty  occupancy status
module cpu_tx_fifo
    import cpu_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  tx_entry_t        i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output tx_entry_t        o_rdata,
    output logic [LVL_W-1:0] o_level,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tx_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // Pointer and level bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (i_push && !i_pop)      r_level <= r_level + LVL_W'(1);
            else if (!i_push && i_pop) r_level <= r_level - LVL_W'(1);
        end
    end

    // Storage needs no reset; the level decides what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/cpu_tx_serializer.sv
// Buffers CPU TX words and serializes them LSB byte first onto an 8-bit
// AXI-Stream master, reporting occupancy and sticky drop errors.
// Ports:
//   s00_axi_aclk, s00_axi_aresetn        clock, async active-low reset
//   push, push_data, push_nbytes         word enqueue strobe + payload
//   flush, clear_sticky                  control strobes
//   m_axis_tvalid/tdata/tlast/tready     byte stream master
//   fifo_level, fifo_full, fifo_empty    queue status (serializer word excluded)
//   busy, overflow_sticky, bad_len_sticky  activity and error status
module cpu_tx_serializer
    import cpu_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [2:0]            push_nbytes,
    input  logic                  flush,
    input  logic                  clear_sticky,
    output logic                  m_axis_tvalid,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  busy,
    output logic                  overflow_sticky,
    output logic                  bad_len_sticky
);

    tx_state_t         r_state;
    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_tvalid;
    logic              r_tlast;
    logic              r_ovf;
    logic              r_bad;

    logic              w_len_ok;
    logic              w_pop;
    logic              w_push_acc;
    logic              w_ovf_set;
    logic              w_bad_set;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    tx_entry_t         w_wdata;
    tx_entry_t         w_head;

    assign w_len_ok      = len_ok(push_nbytes);
    assign w_wdata.nbm1  = 2'(push_nbytes - 3'd1);
    assign w_wdata.data  = WORD_W'(push_data);

    // Pop when idle with work queued, or on the last-byte handshake so the
    // next word follows without a bubble. Flush suppresses the pop so a
    // flushed word never reaches the link.
    assign w_pop = !flush && !w_fifo_empty &&
                   ((r_state == IDLE) ||
                    ((r_state == SEND) && m_axis_tready && r_tlast));

    // A same-cycle pop frees a slot, so a full FIFO may still accept.
    assign w_push_acc = push && w_len_ok && !flush && (!w_fifo_full || w_pop);
    assign w_ovf_set  = push && w_len_ok && !flush && w_fifo_full && !w_pop;
    assign w_bad_set  = push && !w_len_ok && !flush;

    cpu_tx_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .i_clk   (s00_axi_aclk),
        .i_rst_n (s00_axi_aresetn),
        .i_push  (w_push_acc),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_rdata (w_head),
        .o_level (fifo_level),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Serializer FSM; tvalid/tlast are tracked as registers alongside the state.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_remaining <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
        end else if (w_pop) begin
            r_state     <= SEND;
            r_shift     <= w_head.data;
            r_remaining <= CNT_W'(w_head.nbm1) + CNT_W'(1);
            r_tvalid    <= 1'b1;
            r_tlast     <= (w_head.nbm1 == 2'd0);
        end else if ((r_state == SEND) && m_axis_tready) begin
            if (!r_tlast) begin
                r_shift     <= {8'h00, r_shift[WORD_W-1:BYTE_W]};
                r_remaining <= r_remaining - CNT_W'(1);
                r_tlast     <= (r_remaining == CNT_W'(2));
            end else begin
                r_state     <= IDLE;
                r_remaining <= '0;
                r_tvalid    <= 1'b0;
                r_tlast     <= 1'b0;
            end
        end
    end

    // Sticky errors: a set event in the same cycle beats clear_sticky.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_ovf <= 1'b0;
            r_bad <= 1'b0;
        end else begin
            if (w_ovf_set)         r_ovf <= 1'b1;
            else if (clear_sticky) r_ovf <= 1'b0;
            if (w_bad_set)         r_bad <= 1'b1;
            else if (clear_sticky) r_bad <= 1'b0;
        end
    end

    assign m_axis_tvalid   = r_tvalid;
    assign m_axis_tdata    = r_shift[BYTE_W-1:0];
    assign m_axis_tlast    = r_tlast;
    assign fifo_full       = w_fifo_full;
    assign fifo_empty      = w_fifo_empty;
    assign busy            = (r_state != IDLE) || !w_fifo_empty;
    assign overflow_sticky = r_ovf;
    assign bad_len_sticky  = r_bad;

endmodule

// File: tb/tb_cpu_tx_serializer.sv
// Self-checking bench for cpu_tx_serializer: directed scenarios plus a
// randomized run scored against a byte-stream reference model.
module tb_cpu_tx_serializer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LVL_W = 5;

    typedef logic [8:0] beat_t; // {tlast, tdata}

    logic             clk;
    logic             rst_n;
    logic             push;
    logic [31:0]      push_data;
    logic [2:0]       push_nbytes;
    logic             flush;
    logic             clear_sticky;
    logic             m_axis_tvalid;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tlast;
    logic             m_axis_tready;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full;
    logic             fifo_empty;
    logic             busy;
    logic             overflow_sticky;
    logic             bad_len_sticky;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t got[$];
    beat_t exp_q[$];

    localparam logic [19:0] RESET_VEC = {1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    cpu_tx_serializer #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .LVL_W      (LVL_W)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .push            (push),
        .push_data       (push_data),
        .push_nbytes     (push_nbytes),
        .flush           (flush),
        .clear_sticky    (clear_sticky),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .fifo_level      (fifo_level),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .busy            (busy),
        .overflow_sticky (overflow_sticky),
        .bad_len_sticky  (bad_len_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every stream handshake.
    always @(posedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready)
            got.push_back({m_axis_tlast, m_axis_tdata});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] out_vec();
        return {m_axis_tvalid, m_axis_tdata, m_axis_tlast, fifo_level,
                fifo_full, fifo_empty, busy, overflow_sticky, bad_len_sticky};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a word of n bytes becomes n beats, LSB first, last flagged.
    task automatic model_word(input logic [31:0] d, input int n);
        for (int b = 0; b < n; b++)
            exp_q.push_back({logic'(b == n - 1), d[8*b +: 8]});
    endtask

    task automatic wait_idle(input int lim, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < lim; c++) begin
            if (!busy && !m_axis_tvalid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push = 0; push_data = '0; push_nbytes = '0;
        flush = 0; clear_sticky = 0; m_axis_tready = 0;
        #3;
        n_vec++;
        if (out_vec() !== RESET_VEC) begin
            n_err++; $display("FAIL reset_held: got %h expected %h", out_vec(), RESET_VEC);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        n_vec++;
        if (out_vec() !== RESET_VEC) begin
            n_err++; $display("FAIL reset_released: got %h expected %h", out_vec(), RESET_VEC);
        end
    endtask

    task automatic test_single();
        logic [7:0] eb [4];
        eb = '{8'h11, 8'h22, 8'h33, 8'h44};
        push = 1; push_data = 32'h44332211; push_nbytes = 3'd4; m_axis_tready = 1;
        tick();
        push = 0;
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL single_latency: tvalid %b expected 0 one cycle after push", m_axis_tvalid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, logic'(i == 3), eb[i]}) begin
                n_err++; $display("FAIL single_byte%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                                  i, m_axis_tvalid, m_axis_tlast, m_axis_tdata, logic'(i == 3), eb[i]);
            end
        end
        tick();
        n_vec++;
        if ({m_axis_tvalid, busy} !== 2'b00) begin
            n_err++; $display("FAIL single_done: got tvalid=%b busy=%b expected 0 0", m_axis_tvalid, busy);
        end
    endtask

    task automatic test_back_to_back();
        beat_t eb [3];
        eb = '{{1'b0, 8'hDD}, {1'b1, 8'hCC}, {1'b1, 8'h77}};
        m_axis_tready = 1;
        push = 1; push_data = 32'hAABBCCDD; push_nbytes = 3'd2;
        tick();
        push_data = 32'h00000077; push_nbytes = 3'd1;
        tick();
        push = 0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, eb[i]}) begin
                n_err++; $display("FAIL b2b_beat%0d: got v=%b l=%b d=%h expected v=1 beat=%h",
                                  i, m_axis_tvalid, m_axis_tlast, m_axis_tdata, eb[i]);
            end
            tick();
        end
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL b2b_end: tvalid %b expected 0", m_axis_tvalid);
        end
    endtask

    task automatic test_bad_len();
        got.delete();
        m_axis_tready = 1;
        push = 1; push_data = $urandom; push_nbytes = 3'd0;
        tick();
        push_nbytes = 3'd5;
        tick();
        push_nbytes = 3'($urandom_range(5, 7));
        tick();
        push = 0;
        repeat (3) tick();
        n_vec++;
        if ({bad_len_sticky, overflow_sticky, fifo_level, m_axis_tvalid, busy} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL bad_len_status: got bad=%b ovf=%b lvl=%0d v=%b busy=%b expected 1 0 0 0 0",
                              bad_len_sticky, overflow_sticky, fifo_level, m_axis_tvalid, busy);
        end
        n_vec++;
        if (got.size() != 0) begin
            n_err++; $display("FAIL bad_len_traffic: got %0d beats expected 0", got.size());
        end
        push = 1; push_nbytes = 3'd0; clear_sticky = 1;
        tick();
        push = 0; clear_sticky = 0;
        n_vec++;
        if (bad_len_sticky !== 1'b1) begin
            n_err++; $display("FAIL sticky_set_wins: bad_len %b expected 1", bad_len_sticky);
        end
        clear_sticky = 1;
        tick();
        clear_sticky = 0;
        n_vec++;
        if (bad_len_sticky !== 1'b0) begin
            n_err++; $display("FAIL bad_len_clear: bad_len %b expected 0", bad_len_sticky);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w0;
        got.delete(); exp_q.delete();
        m_axis_tready = 0;
        w0 = $urandom;
        for (int i = 0; i < 17; i++) begin
            push = 1; push_data = (i == 0) ? w0 : $urandom; push_nbytes = 3'd4;
            model_word(push_data, 4);
            tick();
        end
        push = 0;
        n_vec++;
        if ({fifo_level, fifo_full, fifo_empty, overflow_sticky} !== {5'd16, 1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL ovf_fill: got lvl=%0d full=%b empty=%b ovf=%b expected 16 1 0 0",
                              fifo_level, fifo_full, fifo_empty, overflow_sticky);
        end
        n_vec++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b0, w0[7:0]}) begin
            n_err++; $display("FAIL ovf_head: got v=%b l=%b d=%h expected 1 0 %h",
                              m_axis_tvalid, m_axis_tlast, m_axis_tdata, w0[7:0]);
        end
        push = 1; push_data = $urandom; push_nbytes = 3'd4;
        tick();
        push = 0;
        n_vec++;
        if ({overflow_sticky, fifo_level} !== {1'b1, 5'd16}) begin
            n_err++; $display("FAIL ovf_drop: got ovf=%b lvl=%0d expected 1 16", overflow_sticky, fifo_level);
        end
        clear_sticky = 1;
        tick();
        clear_sticky = 0;
        n_vec++;
        if ({overflow_sticky, m_axis_tvalid, m_axis_tdata} !== {1'b0, 1'b1, w0[7:0]}) begin
            n_err++; $display("FAIL ovf_clear: got ovf=%b v=%b d=%h expected 0 1 %h",
                              overflow_sticky, m_axis_tvalid, m_axis_tdata, w0[7:0]);
        end
    endtask

    // Continues from the full FIFO left by test_overflow.
    task automatic test_full_push_pop();
        logic found;
        logic ok;
        int   n;
        found = 1'b0;
        m_axis_tready = 1;
        for (int c = 0; c < 8 && !found; c++) begin
            if (m_axis_tvalid && m_axis_tlast) begin
                n = $urandom_range(1, 4);
                push = 1; push_data = $urandom; push_nbytes = 3'(n);
                model_word(push_data, n);
                found = 1'b1;
            end
            tick();
        end
        push = 0;
        n_vec++;
        if (!found) begin
            n_err++; $display("FAIL fpp_no_last: tlast not seen within 8 cycles");
        end
        n_vec++;
        if ({fifo_level, fifo_full, overflow_sticky} !== {5'd16, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL fpp_status: got lvl=%0d full=%b ovf=%b expected 16 1 0",
                              fifo_level, fifo_full, overflow_sticky);
        end
        wait_idle(400, ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL fpp_drain_timeout: busy=%b tvalid=%b", busy, m_axis_tvalid);
        end
        n_vec++;
        if (got.size() != exp_q.size()) begin
            n_err++; $display("FAIL fpp_count: got %0d beats expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_vec++;
            if (got[i] !== exp_q[i]) begin
                n_err++; $display("FAIL fpp_beat%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] w0;
        logic        ok;
        got.delete(); exp_q.delete();
        m_axis_tready = 0;
        w0 = $urandom;
        model_word(w0, 4);
        for (int i = 0; i < 3; i++) begin
            push = 1; push_data = (i == 0) ? w0 : $urandom; push_nbytes = 3'd4;
            tick();
        end
        push = 0;
        tick();
        m_axis_tready = 1;
        tick();
        m_axis_tready = 0;
        flush = 1; push = 1; push_data = $urandom; push_nbytes = 3'd2;
        tick();
        flush = 0; push = 0;
        n_vec++;
        if ({fifo_level, fifo_empty, overflow_sticky, bad_len_sticky} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL flush_status: got lvl=%0d empty=%b ovf=%b bad=%b expected 0 1 0 0",
                              fifo_level, fifo_empty, overflow_sticky, bad_len_sticky);
        end
        n_vec++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b0, w0[15:8]}) begin
            n_err++; $display("FAIL flush_current: got v=%b l=%b d=%h expected 1 0 %h",
                              m_axis_tvalid, m_axis_tlast, m_axis_tdata, w0[15:8]);
        end
        m_axis_tready = 1;
        wait_idle(50, ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL flush_drain_timeout: busy=%b tvalid=%b", busy, m_axis_tvalid);
        end
        n_vec++;
        if (got.size() != exp_q.size()) begin
            n_err++; $display("FAIL flush_count: got %0d beats expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_vec++;
            if (got[i] !== exp_q[i]) begin
                n_err++; $display("FAIL flush_beat%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic       bad_flag;
        logic       pv, pl, pr, ok;
        logic [7:0] pd;
        int         r, n;
        got.delete(); exp_q.delete();
        bad_flag = 1'b0;
        pv = 1'b0; pl = 1'b0; pd = '0; pr = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (pv && !pr) begin
                n_vec++;
                if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, pd, pl}) begin
                    n_err++; $display("FAIL rnd_stall_stable@%0d: got v=%b d=%h l=%b expected 1 %h %b",
                                      c, m_axis_tvalid, m_axis_tdata, m_axis_tlast, pd, pl);
                end
            end
            pv = m_axis_tvalid; pd = m_axis_tdata; pl = m_axis_tlast;
            push = 0;
            if ($urandom_range(0, 3) == 0 && fifo_level <= LVL_W'(DEPTH - 2)) begin
                r = $urandom_range(0, 9);
                if (r < 8)       n = r % 4 + 1;
                else if (r == 8) n = 0;
                else             n = $urandom_range(5, 7);
                push = 1; push_data = $urandom; push_nbytes = 3'(n);
                if (n >= 1 && n <= 4) model_word(push_data, n);
                else                  bad_flag = 1'b1;
            end
            m_axis_tready = logic'($urandom_range(0, 1));
            pr = m_axis_tready;
            tick();
        end
        push = 0;
        m_axis_tready = 1;
        wait_idle(2000, ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL rnd_drain_timeout: busy=%b tvalid=%b", busy, m_axis_tvalid);
        end
        n_vec++;
        if ({bad_len_sticky, overflow_sticky} !== {bad_flag, 1'b0}) begin
            n_err++; $display("FAIL rnd_sticky: got bad=%b ovf=%b expected %b 0",
                              bad_len_sticky, overflow_sticky, bad_flag);
        end
        n_vec++;
        if (got.size() != exp_q.size()) begin
            n_err++; $display("FAIL rnd_count: got %0d beats expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_vec++;
            if (got[i] !== exp_q[i]) begin
                n_err++; $display("FAIL rnd_beat%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        m_axis_tready = 0;
        push = 1; push_data = $urandom; push_nbytes = 3'd3;
        tick();
        push = 1; push_data = $urandom; push_nbytes = 3'd4;
        tick();
        push = 0;
        tick();
        n_vec++;
        if ({m_axis_tvalid, fifo_empty} !== 2'b10) begin
            n_err++; $display("FAIL rmid_pre: got v=%b empty=%b expected 1 0", m_axis_tvalid, fifo_empty);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_vec() !== RESET_VEC) begin
            n_err++; $display("FAIL rmid_async: got %h expected %h", out_vec(), RESET_VEC);
        end
        @(negedge clk) rst_n = 1'b1;
        m_axis_tready = 1;
        tick();
        tick();
        n_vec++;
        if (out_vec() !== RESET_VEC) begin
            n_err++; $display("FAIL rmid_after: got %h expected %h", out_vec(), RESET_VEC);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_len();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_tx_serializer.md
Name: cpu_tx_serializer

Overview:
- Sits directly downstream of the cpu_data_transmitter AXI4-Lite register file.
- Each CPU write to the TX data register arrives as a one-cycle push carrying a 32-bit word and a byte count.
- Words are buffered in a FIFO, then serialized LSB-byte-first onto an 8-bit AXI-Stream master port feeding the peripheral link.
- Status outputs (level, full/empty, sticky errors) return to the register file for CPU readback.

Parameters:
- DATA_WIDTH, 32, push word width; must be 32 (4 bytes).
- DEPTH, 16, FIFO entries; power of two, at least 2.
- LVL_W, $clog2(DEPTH)+1, derived width of fifo_level.

Ports:
- s00_axi_aclk  in  1  sole clock, rising edge.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- push  in  1  one-cycle strobe: enqueue push_data / push_nbytes.
- push_data  in  32  word to transmit.
- push_nbytes  in  3  bytes of the word to send, legal 1..4.
- flush  in  1  one-cycle strobe: discard all queued words.
- clear_sticky  in  1  one-cycle strobe: clear overflow_sticky and bad_len_sticky.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tdata  out  8  stream byte.
- m_axis_tlast  out  1  final byte of the current word.
- m_axis_tready  in  1  stream ready.
- fifo_level  out  LVL_W  queued entries, excluding the word in the serializer.
- fifo_full  out  1  fifo_level == DEPTH.
- fifo_empty  out  1  fifo_level == 0.
- busy  out  1  serializer not IDLE, or FIFO not empty.
- overflow_sticky  out  1  a push was dropped because the FIFO was full.
- bad_len_sticky  out  1  a push was dropped because push_nbytes was 0 or greater than 4.

Behaviour:
- Reset (async assert, sync release) puts every output at 0 except fifo_empty=1. It also clears the FIFO pointers and level, and returns the FSM to IDLE.
- FIFO entry is {nbytes-1 (2b), data (32b)}; storage is a register array with wrap-around read/write pointers.
- Push acceptance: push=1, nbytes in 1..4, and either not full or a pop occurs in the same cycle.
  - Full with no same-cycle pop: entry dropped, overflow_sticky set.
  - Illegal nbytes: entry dropped, bad_len_sticky set, FIFO unchanged.
- Push and pop in the same cycle leave fifo_level unchanged.
- FSM states:
  - IDLE: m_axis_tvalid=0. If FIFO not empty, pop the head into shift register and byte counter, go to SEND.
  - SEND: m_axis_tvalid=1, m_axis_tdata=shift[7:0], m_axis_tlast=(remaining==1). On handshake (tvalid & tready):
    - Not last byte: shift right 8, decrement remaining.
    - Last byte with FIFO not empty: pop the next entry in that same cycle (no bubble), stay in SEND.
    - Last byte with FIFO empty: go to IDLE.
- Latency: a push at edge N into an empty FIFO with the FSM in IDLE pops at edge N+1; m_axis_tvalid is high after N+1, i.e. 2 cycles.
- AXI-Stream rule: while tvalid=1 and tready=0, tdata and tlast stay stable and tvalid does not drop.
- Flush:
  - Resets FIFO pointers and level next edge; a same-cycle push is discarded without setting sticky.
  - The word already in SEND finishes normally and is never truncated.
- Sticky bits: clear_sticky clears both; a set event in the same cycle wins.
- fifo_full, fifo_empty and busy are combinational from registered state.

Decomposition:
- Package cpu_tx_pkg:
  - typedef tx_state_t {IDLE, SEND}.
  - typedef tx_entry_t packed struct {logic [1:0] nbm1; logic [31:0] data;}.
  - localparam BYTES_PER_WORD=4.
- Sub-module cpu_tx_fifo: parameterized sync FIFO with push/pop/flush and level/full/empty outputs.
- cpu_tx_serializer instantiates cpu_tx_fifo and contains the FSM and sticky logic.

Test Plan:
- Reset then push 0x44332211 with nbytes=4, tready=1: bytes 11,22,33,44 on consecutive cycles, tlast only on 44; tvalid rises 2 cycles after push; busy=0 afterwards.
- Push 0xAABBCCDD with nbytes=2, then 0x00000077 with nbytes=1, tready=1: stream DD,CC(tlast),77(tlast) with no idle cycle between CC and 77.
- Hold tready=0 and push 17 words with nbytes=4: one word enters the serializer, level=16, full=1. Then push an 18th word: overflow_sticky=1, level stays 16. Then clear_sticky: overflow_sticky=0.
- Push with nbytes=0, then nbytes=5: bad_len_sticky=1, level=0, no stream traffic.
- With FIFO full and tready=1 at a last-byte handshake, push in the same cycle: push accepted, level stays 16, overflow_sticky=0.
- Queue 3 words and stall tready=0 mid-word, then flush: level=0. After tready=1 the current word completes with correct tlast, then tvalid=0. Assert reset mid-SEND: all outputs return to reset values immediately.
